// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing the LCD sprite-draw engine between the sprite
// requesters (dino, obstacle, score, ground). A game-state change schedules one
// full-screen clear, which is served ahead of any pending sprite request.

package draw_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, WIN, OVER} state_t;
endpackage

module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  state_t             state,
  input  logic [NUM_REQ-1:0] req,
  input  logic               draw_done,
  output logic [NUM_REQ-1:0] grant,
  output logic               clear,
  output logic               draw_start,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ARB, WAIT_SPR, WAIT_CLR} fsm_t;

  fsm_t               fsm, fsm_nxt;
  state_t             prev_state;
  logic               clear_pending, pend_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt;
  logic               clear_nxt, start_nxt, busy_nxt, terr_nxt;

  logic               state_chg;
  logic [IDX_W:0]     pick;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   idx_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cnt_hit;

  // First set request scanning ptr, ptr+1, ... with wrap; MSB flags a hit.
  // Scanning from the farthest offset down lets the nearest hit win.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] j;
    logic [IDX_W:0]   res;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign state_chg = (state != prev_state);
  assign pick      = rr_pick(req, rr_ptr);
  assign pick_vld  = pick[IDX_W];
  assign pick_idx  = pick[IDX_W-1:0];
  assign idx_inc   = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  assign cnt_inc   = cnt + 1'b1;
  // The counter reaches TIMEOUT_CYC on this edge; a simultaneous draw_done wins.
  assign cnt_hit   = (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // Next-state and next-output decode for the arbitration FSM.
  always_comb begin
    fsm_nxt   = fsm;
    grant_nxt = grant;
    clear_nxt = clear;
    start_nxt = 1'b0;
    done_nxt  = '0;
    busy_nxt  = busy;
    terr_nxt  = timeout_err;
    rr_nxt    = rr_ptr;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    pend_nxt  = clear_pending | state_chg;
    case (fsm)
      ARB: begin
        // Nothing is issued while a done pulse is out, so the finished
        // requester gets a cycle to drop its request.
        if (done == '0) begin
          if (clear_pending) begin
            clear_nxt = 1'b1;
            start_nxt = 1'b1;
            busy_nxt  = 1'b1;
            pend_nxt  = state_chg;
            cnt_nxt   = '0;
            fsm_nxt   = WAIT_CLR;
          end else if (pick_vld) begin
            grant_nxt = NUM_REQ'(1) << pick_idx;
            start_nxt = 1'b1;
            busy_nxt  = 1'b1;
            idx_nxt   = pick_idx;
            cnt_nxt   = '0;
            fsm_nxt   = WAIT_SPR;
          end
        end
      end
      WAIT_SPR: begin
        if (draw_done) begin
          grant_nxt     = '0;
          busy_nxt      = 1'b0;
          done_nxt[idx] = 1'b1;
          rr_nxt        = idx_inc;
          cnt_nxt       = '0;
          fsm_nxt       = ARB;
        end else if (cnt_hit) begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          terr_nxt  = 1'b1;
          rr_nxt    = idx_inc;
          cnt_nxt   = '0;
          fsm_nxt   = ARB;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_CLR: begin
        if (draw_done) begin
          clear_nxt = 1'b0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          fsm_nxt   = ARB;
        end else if (cnt_hit) begin
          clear_nxt = 1'b0;
          busy_nxt  = 1'b0;
          terr_nxt  = 1'b1;
          cnt_nxt   = '0;
          fsm_nxt   = ARB;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        fsm_nxt   = ARB;
        grant_nxt = '0;
        clear_nxt = 1'b0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register; reset abandons any transaction without a done or error.
  always_ff @(posedge clk) begin
    prev_state <= state;
    if (rst) begin
      fsm           <= ARB;
      grant         <= '0;
      clear         <= 1'b0;
      draw_start    <= 1'b0;
      done          <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      rr_ptr        <= '0;
      idx           <= '0;
      cnt           <= '0;
      clear_pending <= 1'b0;
    end else begin
      fsm           <= fsm_nxt;
      grant         <= grant_nxt;
      clear         <= clear_nxt;
      draw_start    <= start_nxt;
      done          <= done_nxt;
      busy          <= busy_nxt;
      timeout_err   <= terr_nxt;
      rr_ptr        <= rr_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      clear_pending <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: a default instance for the arbitration and
// clear-scheduling scenarios, and a short-timeout instance for abort cases.

module tb_draw_arbiter;
  import draw_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  state_t     state;
  logic [3:0] req;
  logic       draw_done;

  logic [3:0] grant, done;
  logic       clear, draw_start, busy, timeout_err;
  logic [3:0] t_grant, t_done;
  logic       t_clear, t_start, t_busy, t_terr;

  int n_chk = 0;
  int n_err = 0;
  int n_clr;
  logic [3:0] exp_seq [5];

  draw_arbiter dut (
    .clk(clk), .rst(rst), .state(state), .req(req), .draw_done(draw_done),
    .grant(grant), .clear(clear), .draw_start(draw_start), .done(done),
    .busy(busy), .timeout_err(timeout_err)
  );

  draw_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(8)) dut_to (
    .clk(clk), .rst(rst), .state(state), .req(req), .draw_done(draw_done),
    .grant(t_grant), .clear(t_clear), .draw_start(t_start), .done(t_done),
    .busy(t_busy), .timeout_err(t_terr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input state_t s);
    rst = 1'b1; req = '0; draw_done = 1'b0; state = s;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Test 1: single request, completion, one-cycle gap before re-grant
    reset_dut(RUN);
    chk("rst grant", grant, 0);
    chk("rst clear", clear, 0);
    chk("rst start", draw_start, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst terr", timeout_err, 0);
    req = 4'b0001;
    tick();
    chk("t1 grant", grant, 4'b0001);
    chk("t1 start", draw_start, 1);
    chk("t1 busy", busy, 1);
    tick();
    chk("t1 start pulse", draw_start, 0);
    chk("t1 grant held", grant, 4'b0001);
    repeat (8) tick();
    pulse_done();
    chk("t1 done", done, 4'b0001);
    chk("t1 grant drop", grant, 0);
    chk("t1 busy drop", busy, 0);
    tick();
    chk("t1 done width", done, 0);
    chk("t1 no regrant", grant, 0);
    tick();
    chk("t1 regrant", grant, 4'b0001);
    req = '0;
    pulse_done();
    tick();

    // Test 2: round-robin with all requests held
    reset_dut(RUN);
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2 grant%0d", k), grant, exp_seq[k]);
      chk($sformatf("t2 start%0d", k), draw_start, 1);
      repeat (4) tick();
      pulse_done();
      chk($sformatf("t2 done%0d", k), done, exp_seq[k]);
      chk($sformatf("t2 drop%0d", k), grant, 0);
      tick();
      chk($sformatf("t2 gap%0d", k), grant, 0);
      if (k == 4) req = '0;
      tick();
    end
    chk("t2 idle", grant, 0);

    // Test 3: state change mid-sprite queues a clear ahead of pending req[0]
    req = 4'b0011;
    tick();
    chk("t3 grant", grant, 4'b0010);
    tick();
    state = OVER;
    tick(); tick();
    pulse_done();
    chk("t3 done", done, 4'b0010);
    chk("t3 no clear yet", clear, 0);
    tick();
    chk("t3 gap clear", clear, 0);
    chk("t3 gap grant", grant, 0);
    tick();
    chk("t3 clear", clear, 1);
    chk("t3 clear start", draw_start, 1);
    chk("t3 clear no grant", grant, 0);
    chk("t3 clear busy", busy, 1);
    tick();
    chk("t3 clear held", clear, 1);
    pulse_done();
    chk("t3 clear drop", clear, 0);
    chk("t3 clear no done", done, 0);
    chk("t3 clear busy drop", busy, 0);
    tick();
    chk("t3 grant after clear", grant, 4'b0001);
    chk("t3 start after clear", draw_start, 1);
    req = '0;
    pulse_done();
    tick();

    // Test 4: IDLE->RUN->IDLE inside a transaction collapses to one clear
    reset_dut(IDLE);
    req = 4'b0100;
    tick();
    chk("t4 grant", grant, 4'b0100);
    req = '0;
    state = RUN;
    tick();
    state = IDLE;
    tick(); tick();
    pulse_done();
    chk("t4 done", done, 4'b0100);
    tick();
    tick();
    chk("t4 clear", clear, 1);
    tick();
    pulse_done();
    chk("t4 clear drop", clear, 0);
    n_clr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clear || draw_start) n_clr++;
    end
    chk("t4 extra clears", n_clr, 0);

    // Test 5: timeout after 8 wait cycles, then draw_done exactly on the 8th
    reset_dut(IDLE);
    req = 4'b0100;
    tick();
    chk("t5 grant", t_grant, 4'b0100);
    repeat (7) tick();
    chk("t5 held at 7", t_grant, 4'b0100);
    chk("t5 terr early", t_terr, 0);
    tick();
    chk("t5 timeout grant", t_grant, 0);
    chk("t5 timeout busy", t_busy, 0);
    chk("t5 timeout terr", t_terr, 1);
    chk("t5 timeout done", t_done, 0);
    req = 4'b1111;
    tick();
    chk("t5 next scan", t_grant, 4'b1000);
    chk("t5 terr sticky", t_terr, 1);
    tick();
    pulse_done();
    chk("t5 done idx3", t_done, 4'b1000);
    req = 4'b0100;
    tick();
    tick();
    chk("t5 grant2", t_grant, 4'b0100);
    repeat (7) tick();
    pulse_done();
    chk("t5 edge done", t_done, 4'b0100);
    chk("t5 edge grant", t_grant, 0);
    chk("t5 edge terr", t_terr, 1);
    req = '0;
    tick();
    chk("t5 terr hold", t_terr, 1);
    chk("t5 done width", t_done, 0);

    // Test 6: reset during WAIT_SPR abandons the transaction and rr_ptr
    reset_dut(RUN);
    req = 4'b0100;
    tick();
    tick();
    pulse_done();
    chk("t6 done", done, 4'b0100);
    tick();
    tick();
    chk("t6 grant", grant, 4'b0100);
    tick();
    rst = 1'b1;
    req = 4'b1001;
    tick();
    chk("t6 rst grant", grant, 0);
    chk("t6 rst clear", clear, 0);
    chk("t6 rst start", draw_start, 0);
    chk("t6 rst done", done, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst terr", timeout_err, 0);
    rst = 1'b0;
    tick();
    chk("t6 regrant ptr0", grant, 4'b0001);
    chk("t6 regrant start", draw_start, 1);
    tick();
    pulse_done();
    chk("t6 done after rst", done, 4'b0001);
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
